dp_memory_arbiter: RTL and testbench
====================================

DP_MEMORY_ARBITER -- requirements
Module: dp_memory_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 13: address width of the memory and of both requesters.
REQ-002 Parameter DATA_WIDTH, default 32: data width of the memory and of both requesters.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 mN_valid  input  1  (N=0,1) requester N presents a transaction.
REQ-007 mN_ready  output  1  transaction of requester N accepted this cycle.
REQ-008 mN_we  input  1  1 = write, 0 = read.
REQ-009 mN_addr  input  ADDRESS_WIDTH  word address.
REQ-010 mN_wdata  input  DATA_WIDTH  write data.
REQ-011 mN_rvalid  output  1  one-cycle pulse: mN_rdata holds read data.
REQ-012 mN_rdata  output  DATA_WIDTH  read data.
REQ-013 mem_ce_a, mem_we  output  1 each  port A enable and write strobe (writes only).
REQ-014 mem_addr_a  output  ADDRESS_WIDTH; mem_datain  output  DATA_WIDTH  port A write address and data.
REQ-015 mem_ce_b, mem_re  output  1 each  port B enable and read strobe (reads only).
REQ-016 mem_addr_b  output  ADDRESS_WIDTH  port B read address.
REQ-017 mem_dataout  input  DATA_WIDTH  memory read data, valid one clock after mem_re.

Function
REQ-018 Handshake: a transaction SHALL complete in the cycle mN_valid && mN_ready; mN_ready SHALL be combinational from current valids, we, addr and the priority pointer, and never asserted without mN_valid.
REQ-019 Writes SHALL issue on port A only, reads on port B only; memory strobes SHALL be driven combinationally in the handshake cycle.
REQ-020 Single valid requester: SHALL be granted the same cycle.
REQ-021 Both valid, one write and one read, addresses differ: both SHALL be granted the same cycle (write on A, read on B); priority pointer unchanged.
REQ-022 Both valid, same type (both reads or both writes): only the requester holding priority SHALL be granted; pointer SHALL then pass to the other requester.
REQ-023 Both valid, one write and one read, same address: only the priority holder SHALL be granted; pointer SHALL pass to the other requester.
REQ-024 Priority pointer: 1-bit register, value = requester holding priority; it changes only on a contended cycle (REQ-022/023).
REQ-025 Read latency: mN_rvalid SHALL pulse exactly one cycle after the read handshake, with mN_rdata = mem_dataout in that cycle; the other requester's rvalid stays 0.
REQ-026 mN_rdata SHALL hold its last value when mN_rvalid is 0.
REQ-027 Back-to-back reads from either requester SHALL sustain one read per cycle; rvalid pulses follow handshakes in order with no gaps.
REQ-028 Idle (no valid): mem_ce_a, mem_we, mem_ce_b, mem_re SHALL be 0; address and data outputs are don't-care.
REQ-029 A requester SHALL not be starved: under continuous contention grants alternate 0,1,0,1...
REQ-030 Address arithmetic: addresses pass unmodified; no wrap or range checking.

Reset
REQ-031 While rst=1: both mN_ready=0, all memory strobes=0, both mN_rvalid=0, mN_rdata=0, pointer=0 (requester 0 priority).
REQ-032 A read accepted in the cycle before reset asserts SHALL NOT produce an rvalid pulse while rst=1.
REQ-033 First cycle after rst deasserts: normal arbitration with requester 0 holding priority.

Verification
REQ-034 Reset, then m0 write addr 0x0005 data 0xDEADBEEF; next cycle m0 read 0x0005 -> mem_ce_a/mem_we high in cycle 1, m0_rvalid in cycle 3 with m0_rdata=0xDEADBEEF.
REQ-035 m0 write 0x0010 and m1 read 0x0020 in the same cycle -> both ready=1, mem_ce_a and mem_ce_b both high, pointer unchanged, m1_rvalid next cycle.
REQ-036 Both requesters read continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; each rvalid pulse routed only to the granted requester.
REQ-037 m0 write 0x0100 and m1 read 0x0100 in the same cycle with pointer=1 -> only m1 granted, read returns pre-write data; m0 granted next cycle; pointer=0 afterwards.
REQ-038 m1 read handshake at cycle T, rst=1 at T+1 -> m1_rvalid=0 at T+1, m1_rdata=0, pointer=0 after reset.
REQ-039 Write to 0x1FFF then read 0x1FFF -> data returned unchanged (top-of-range address).

Source files
------------

// File: rtl/dp_memory_arbiter.sv
// Two-requester arbiter onto a dual-port memory: writes on port A, reads on port B.
// Latency: grant and memory strobes combinational in the handshake cycle; read data one cycle later.
// Backpressure: m*_ready drops for the non-priority requester on same-type or same-address conflicts.
module dp_memory_arbiter #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     m0_valid_i,
    output logic                     m0_ready_o,
    input  logic                     m0_we_i,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0]    m0_wdata_i,
    output logic                     m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]    m0_rdata_o,

    input  logic                     m1_valid_i,
    output logic                     m1_ready_o,
    input  logic                     m1_we_i,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0]    m1_wdata_i,
    output logic                     m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]    m1_rdata_o,

    output logic                     mem_ce_a_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_a_o,
    output logic [DATA_WIDTH-1:0]    mem_datain_o,
    output logic                     mem_ce_b_o,
    output logic                     mem_re_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_b_o,
    input  logic [DATA_WIDTH-1:0]    mem_dataout_i
);

    // Priority pointer: value is the requester that wins the next contended cycle.
    logic ptr_q, ptr_d;
    logic gnt0, gnt1;
    logic wr0, wr1, rd0, rd1;

    // Read-return tracking: one outstanding read per cycle, tagged with its owner.
    logic rd_vld_q, rd_vld_d;
    logic rd_id_q, rd_id_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    // Arbitration: a write and a read to different addresses can share the two ports;
    // anything else with both requesters valid goes to the pointer holder and flips it.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ptr_d = ptr_q;
        if (m0_valid_i && m1_valid_i) begin
            if ((m0_we_i != m1_we_i) && (m0_addr_i != m1_addr_i)) begin
                gnt0 = 1'b1;
                gnt1 = 1'b1;
            end else begin
                gnt0  = ~ptr_q;
                gnt1  = ptr_q;
                ptr_d = ~ptr_q;
            end
        end else begin
            gnt0 = m0_valid_i;
            gnt1 = m1_valid_i;
        end
        if (rst_i) begin
            gnt0  = 1'b0;
            gnt1  = 1'b0;
            ptr_d = 1'b0;
        end
    end

    // Port steering: granted write onto port A, granted read onto port B.
    always_comb begin
        wr0          = gnt0 & m0_we_i;
        wr1          = gnt1 & m1_we_i;
        rd0          = gnt0 & ~m0_we_i;
        rd1          = gnt1 & ~m1_we_i;
        mem_ce_a_o   = wr0 | wr1;
        mem_we_o     = wr0 | wr1;
        mem_addr_a_o = wr1 ? m1_addr_i  : m0_addr_i;
        mem_datain_o = wr1 ? m1_wdata_i : m0_wdata_i;
        mem_ce_b_o   = rd0 | rd1;
        mem_re_o     = rd0 | rd1;
        mem_addr_b_o = rd1 ? m1_addr_i  : m0_addr_i;
        rd_vld_d     = rd0 | rd1;
        rd_id_d      = rd1;
    end

    assign m0_ready_o = gnt0;
    assign m1_ready_o = gnt1;

    // Return path: the memory answers one cycle after the strobe, so data passes straight
    // through in the pulse cycle and is held afterwards. Reset masks a read still in flight.
    always_comb begin
        m0_rvalid_o = rd_vld_q & ~rd_id_q & ~rst_i;
        m1_rvalid_o = rd_vld_q &  rd_id_q & ~rst_i;
        m0_rdata_o  = rst_i ? '0 : (m0_rvalid_o ? mem_dataout_i : rdata0_q);
        m1_rdata_o  = rst_i ? '0 : (m1_rvalid_o ? mem_dataout_i : rdata1_q);
    end

    // State update: pointer, read tracking and held read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_id_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
            if (m0_rvalid_o) rdata0_q <= mem_dataout_i;
            if (m1_rvalid_o) rdata1_q <= mem_dataout_i;
        end
    end

endmodule

// File: tb/tb_dp_memory_arbiter.sv
// Randomized and directed bench for dp_memory_arbiter against a transaction-level model.
// Latency: checks each cycle at the falling edge; read returns checked one cycle after grant.
// Backpressure: model decides which requester is accepted and compares every ready.
module tb_dp_memory_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk, rst;
    logic          m0_valid, m0_ready, m0_we, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid, m1_ready, m1_we, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_ce_a, mem_we, mem_ce_b, mem_re;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [DW-1:0] mem_datain, mem_dataout;

    dp_memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_we_i(m0_we),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_we_i(m1_we),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .mem_ce_a_o(mem_ce_a), .mem_we_o(mem_we), .mem_addr_a_o(mem_addr_a),
        .mem_datain_o(mem_datain), .mem_ce_b_o(mem_ce_b), .mem_re_o(mem_re),
        .mem_addr_b_o(mem_addr_b), .mem_dataout_i(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port memory: write on A, registered read on B (read sees pre-write contents).
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_ce_a && mem_we) ram[mem_addr_a] <= mem_datain;
        if (mem_ce_b && mem_re) mem_dataout <= ram[mem_addr_b];
    end

    // Reference model state: memory image, priority owner, read in flight, held read data.
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
    int            mdl_pri;
    bit            pend_vld;
    int            pend_who;
    logic [DW-1:0] pend_dat;
    logic [DW-1:0] hold [2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock of traffic: drive, then compare DUT against the model, then advance the model.
    task automatic cyc(input bit r,
                       input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit g [2];
        bit vv [2];
        bit ww [2];
        logic [AW-1:0] aa [2];
        logic [DW-1:0] dd [2];
        bit contended, exp_rv;
        bit wr_any, rd_any;
        int wr_who, rd_who;
        @(posedge clk); #1;
        rst = r;
        m0_valid = v0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_valid = v1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        vv[0] = v0; ww[0] = w0; aa[0] = a0; dd[0] = d0;
        vv[1] = v1; ww[1] = w1; aa[1] = a1; dd[1] = d1;
        @(negedge clk);

        g[0] = 0; g[1] = 0; contended = 0;
        if (!r) begin
            if (vv[0] && vv[1]) begin
                if (ww[0] != ww[1] && aa[0] != aa[1]) begin
                    g[0] = 1; g[1] = 1;
                end else begin
                    contended = 1;
                    g[mdl_pri] = 1;
                end
            end else begin
                g[0] = vv[0]; g[1] = vv[1];
            end
        end
        wr_any = 0; rd_any = 0; wr_who = 0; rd_who = 0;
        for (int i = 0; i < 2; i++) begin
            if (g[i] && ww[i])  begin wr_any = 1; wr_who = i; end
            if (g[i] && !ww[i]) begin rd_any = 1; rd_who = i; end
        end

        check("m0_ready", 32'(m0_ready), 32'(g[0]));
        check("m1_ready", 32'(m1_ready), 32'(g[1]));
        check("mem_ce_a", 32'(mem_ce_a), 32'(wr_any));
        check("mem_we",   32'(mem_we),   32'(wr_any));
        check("mem_ce_b", 32'(mem_ce_b), 32'(rd_any));
        check("mem_re",   32'(mem_re),   32'(rd_any));
        if (wr_any) begin
            check("mem_addr_a", 32'(mem_addr_a), 32'(aa[wr_who]));
            check("mem_datain", mem_datain, dd[wr_who]);
        end
        if (rd_any) check("mem_addr_b", 32'(mem_addr_b), 32'(aa[rd_who]));

        for (int i = 0; i < 2; i++) begin
            logic          rv_obs;
            logic [DW-1:0] rd_obs, rd_exp;
            rv_obs = (i == 0) ? m0_rvalid : m1_rvalid;
            rd_obs = (i == 0) ? m0_rdata  : m1_rdata;
            exp_rv = !r && pend_vld && pend_who == i;
            if (r)           rd_exp = '0;
            else if (exp_rv) rd_exp = pend_dat;
            else             rd_exp = hold[i];
            check(i == 0 ? "m0_rvalid" : "m1_rvalid", 32'(rv_obs), 32'(exp_rv));
            check(i == 0 ? "m0_rdata"  : "m1_rdata",  rd_obs, rd_exp);
            if (!r && exp_rv) hold[i] = pend_dat;
        end

        if (r) begin
            mdl_pri  = 0;
            pend_vld = 0;
            hold[0]  = '0;
            hold[1]  = '0;
        end else begin
            pend_vld = rd_any;
            pend_who = rd_who;
            if (rd_any) pend_dat = mdl_mem[aa[rd_who]];
            if (wr_any) mdl_mem[aa[wr_who]] = dd[wr_who];
            if (contended) mdl_pri = 1 - mdl_pri;
        end
    endtask

    task automatic idle(input bit r);
        cyc(r, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        rst = 1; m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = '0;
            mdl_mem[i] = '0;
        end
        mem_dataout = '0;
        mdl_pri = 0; pend_vld = 0; pend_who = 0; pend_dat = '0;
        hold[0] = '0; hold[1] = '0;

        idle(1); idle(1);

        // Write then read back the same word on requester 0.
        cyc(0, 1, 1, 13'h0005, 32'hDEADBEEF, 0, 0, '0, '0);
        cyc(0, 1, 0, 13'h0005, '0,           0, 0, '0, '0);
        idle(0);
        check("wr_rd_0005", m0_rdata, 32'hDEADBEEF);

        // Concurrent write and read to different addresses share the ports.
        cyc(0, 1, 1, 13'h0010, 32'h11112222, 1, 0, 13'h0020, '0);
        idle(0);

        // Continuous contention on reads alternates grants starting with requester 0.
        idle(1);
        for (int k = 0; k < 6; k++)
            cyc(0, 1, 0, 13'(k), '0, 1, 0, 13'(k + 8), '0);
        idle(0);

        // Same-address write/read conflict with pointer at 1: read wins and sees old data.
        cyc(0, 1, 1, 13'h0100, 32'hCAFE0001, 0, 0, '0, '0);
        idle(1);
        cyc(0, 1, 0, 13'h0001, '0, 1, 0, 13'h0002, '0);
        cyc(0, 1, 1, 13'h0100, 32'hCAFE0002, 1, 0, 13'h0100, '0);
        cyc(0, 1, 1, 13'h0100, 32'hCAFE0002, 0, 0, '0, '0);
        check("pre_write_data", m1_rdata, 32'hCAFE0001);
        cyc(0, 1, 0, 13'h0003, '0, 1, 0, 13'h0004, '0);

        // Read in flight when reset asserts must not return.
        cyc(0, 0, 0, '0, '0, 1, 0, 13'h0020, '0);
        idle(1);
        cyc(0, 1, 0, 13'h0005, '0, 1, 0, 13'h0006, '0);
        idle(0);

        // Top-of-range address.
        cyc(0, 0, 0, '0, '0, 1, 1, 13'h1FFF, 32'hA5A55A5A);
        cyc(0, 0, 0, '0, '0, 1, 0, 13'h1FFF, '0);
        idle(0);
        check("top_addr", m1_rdata, 32'hA5A55A5A);

        // Random traffic over a small address window to provoke conflicts.
        for (int n = 0; n < 3000; n++) begin
            bit r;
            logic [AW-1:0] a0, a1;
            r  = ($urandom_range(0, 59) == 0);
            a0 = ($urandom_range(0, 15) == 0) ? 13'h1FFF : 13'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 15) == 0) ? 13'h1FFF : 13'($urandom_range(0, 7));
            cyc(r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a0, $urandom,
                   ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a1, $urandom);
        end
        idle(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
